// File: rtl/slice_adder_seq_if.sv
// Producer/consumer handshake bundle for slice_adder_seq.
// The sub line exists only when SUBTRACT_EN is defined.
interface slice_adder_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SUBTRACT_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, a, b, c_in,
`ifdef SUBTRACT_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, c_in,
`ifdef SUBTRACT_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, c_out
  );
endinterface

// File: rtl/slice_adder_seq.sv
// Wide adder reusing one 4-bit lookahead slice per cycle, LSB nibble first (SUBTRACT_EN adds a - b).
// Latency: NSLICE = WIDTH/4 cycles from accept to out_valid; issue interval NSLICE+2.
// Backpressure: result and c_out held in DONE until out_ready; in_ready low while busy.
module slice_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  slice_adder_seq_if.slave   bus,
  output logic               busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("slice_adder_seq: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;

  logic [WIDTH-1:0]   b_eff;
  logic               carry_init;
  logic [IDX_W+1:0]   bit_base;
  logic [3:0]         a_nib;
  logic [3:0]         b_nib;
  logic [3:0]         g;
  logic [3:0]         p;
  logic [4:0]         c;
  logic [3:0]         slice_sum;
  logic               last_slice;

  // Subtraction folds into the operands at accept: a + ~b + 1.
`ifdef SUBTRACT_EN
  always_comb begin
    b_eff      = bus.sub ? ~bus.b : bus.b;
    carry_init = bus.sub ? 1'b1   : bus.c_in;
  end
`else
  always_comb begin
    b_eff      = bus.b;
    carry_init = bus.c_in;
  end
`endif

  // One 4-bit carry-lookahead slice selected by idx.
  always_comb begin
    bit_base  = {idx_q, 2'b00};
    a_nib     = a_q[bit_base +: 4];
    b_nib     = b_q[bit_base +: 4];
    g         = a_nib & b_nib;
    p         = a_nib ^ b_nib;
    c[0]      = carry_q;
    c[1]      = g[0] | (p[0] & c[0]);
    c[2]      = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]      = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
    c[4]      = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
    slice_sum = p ^ c[3:0];
  end

  assign last_slice = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= b_eff;
            carry_q <= carry_init;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[bit_base +: 4] <= slice_sum;
          carry_q              <= c[4];
          idx_q                <= idx_q + IDX_W'(1);
          if (last_slice) c_out_q <= c[4];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;

endmodule

// File: tb/tb_slice_adder_seq.sv
// Scoreboard bench for slice_adder_seq: driver pushes model results, monitor pops on each result handshake.
module tb_slice_adder_seq;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;
`ifdef SUBTRACT_EN
  localparam bit SUB_OK = 1'b1;
`else
  localparam bit SUB_OK = 1'b0;
`endif

  typedef struct {
    logic [W:0] res;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   rand_rdy = 1'b0;
  logic prev_vld = 1'b0;
  exp_t q[$];

  slice_adder_seq_if #(.WIDTH(W)) bus ();

  slice_adder_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + 17'd1;
    return {1'b0, a} + {1'b0, b} + {16'd0, ci};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic s, output int acc);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
`ifdef SUBTRACT_EN
    bus.sub      = s;
`endif
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc   = cyc;
        e.res = model(a, b, ci, s);
        e.acc = cyc;
        q.push_back(e);
        break;
      end
    end
    if (acc < 0) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on out_valid rise, result compare on each output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.out_valid && !prev_vld) begin
          if (q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
          else check("latency", 32'(cyc - q[0].acc), 32'(NSLICE + 1));
        end
        if (bus.out_valid && bus.out_ready && q.size() > 0) begin
          e = q.pop_front();
          check("sum", 32'(bus.sum), 32'(e.res[W-1:0]));
          check("c_out", 32'(bus.c_out), 32'(e.res[W]));
        end
      end
      prev_vld = bus.out_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int acc1, acc2;
    bit got;
    logic [W-1:0] ra, rb;
    logic rs;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
`ifdef SUBTRACT_EN
    bus.sub       = 1'b0;
`endif
    bus.out_ready = 1'b1;

    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed carry cases.
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, acc1);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc1);
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, acc1);
    drain();

    // Backpressure: result held, new operands refused.
    bus.out_ready = 1'b0;
    issue(16'h0F0F, 16'h1010, 1'b1, 1'b0, acc1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("bp_out_valid_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a        = 16'h7777;
    bus.b        = 16'h1234;
    repeat (5) begin
      @(negedge clk);
      check("bp_sum_hold", 32'(bus.sum), 32'h1F20);
      check("bp_c_out_hold", 32'(bus.c_out), 32'd0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
    check("bp_nothing_taken", 32'(q.size()), 32'd0);

    // Back-to-back issue interval.
    issue(16'd1, 16'd2, 1'b0, 1'b0, acc1);
    issue(16'd3, 16'd4, 1'b0, 1'b0, acc2);
    check("b2b_interval", 32'(acc2 - acc1), 32'(NSLICE + 2));
    drain();

    // Reset two cycles into RUN.
    issue(16'hABCD, 16'h1357, 1'b0, 1'b0, acc1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_c_out", 32'(bus.c_out), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, acc1);
    drain();

`ifdef SUBTRACT_EN
    issue(16'h0007, 16'h0005, 1'b1, 1'b1, acc1);
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, acc1);
    drain();
`endif

    // Random operands with random consumer stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ra = (n % 7 == 0) ? 16'hFFFF : 16'($urandom);
      rb = (n % 5 == 0) ? 16'h0001 : 16'($urandom);
      rs = SUB_OK ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(ra, rb, 1'($urandom_range(0, 1)), rs, acc1);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
